// File: rtl/register_arbiter.sv
// Arbitrates N requesters onto the write port of one external W-bit enabled register.
// Define REGARB_FIXED_PRIO_EN to make the lowest set request index always win instead of round-robin.
module register_arbiter #(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  wdata,
    output logic [N-1:0]    ack,
    output logic [W-1:0]    reg_d,
    output logic            reg_enb,
    output logic [IW-1:0]   gnt_id,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_ACK
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_gnt;
    logic [W-1:0]    r_d;
    logic            r_enb;
    logic [N-1:0]    r_ack;
    logic            r_busy;
    logic [IW-1:0]   w_winner;
    logic            w_found;
    logic [W-1:0]    w_slot [N];

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_slot[i] = wdata[i*W +: W];
        end
    end

`ifdef REGARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && req[i]) begin
                w_winner = IW'(i);
                w_found  = 1'b1;
            end
        end
    end
`else
    logic [IW-1:0]  r_rr_ptr;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_sum;

    // Rotate the request vector so index 0 is the highest-priority slot, then map back modulo N.
    always_comb begin
        w_dbl    = {req, req};
        w_rot    = N'(w_dbl >> r_rr_ptr);
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
                if (w_sum >= (IW+1)'(N)) begin
                    w_sum = w_sum - (IW+1)'(N);
                end
                w_winner = IW'(w_sum);
                w_found  = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_d     <= '0;
            r_enb   <= 1'b0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            r_rr_ptr <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack  <= '0;
                    r_enb  <= 1'b0;
                    r_busy <= 1'b0;
                    if (|req) begin
                        r_gnt   <= w_winner;
                        r_d     <= w_slot[w_winner];
                        r_enb   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_enb        <= 1'b0;
                    r_ack        <= '0;
                    r_ack[r_gnt] <= 1'b1;
                    r_state      <= S_ACK;
                end
                S_ACK: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifndef REGARB_FIXED_PRIO_EN
                    r_rr_ptr <= (r_gnt == IW'(N-1)) ? '0 : r_gnt + 1'b1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack     = r_ack;
    assign reg_d   = r_d;
    assign reg_enb = r_enb;
    assign gnt_id  = r_gnt;
    assign busy    = r_busy;

endmodule
